chinx_memarb: RTL and testbench
===============================

Name: chinx_memarb

Overview:
- Two-requester arbiter/sequencer for the single chinx_mem32 data port.
- Requester 0 is the CPU stage2 load/store path; requester 1 is a secondary master (DMA/debug loader).
- Grants one requester at a time, holds its request on the memory port for MEM_LAT cycles, then returns read data or a write completion strobe.
- Sits between stage2/secondary master and mem32 on the sysclk domain.

Parameters:
ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH)
DATA_WIDTH, 32, data width (matches `DATA_WIDTH)
OPND_WIDTH, 2, memory operand-size field width (matches `MEM_OPND_WIDTH)
MEM_LAT, 1, cycles the memory port is held per access; legal range 1..15
CPU_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties

Ports:
clk  in  1  system clock (sysclk)
rst  in  1  asynchronous reset, active high
req0  in  1  requester 0 access request, level
we0  in  1  requester 0 write enable
opnd0  in  OPND_WIDTH  requester 0 operand size
addr0  in  ADDR_WIDTH  requester 0 address
wdata0  in  DATA_WIDTH  requester 0 write data
gnt0  out  1  requester 0 grant, one-cycle pulse
rvalid0  out  1  requester 0 completion, one-cycle pulse
rdata0  out  DATA_WIDTH  requester 0 read data, valid with rvalid0
req1, we1, opnd1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
mem_ce  out  1  write enable to mem32 ce
mem_opnd  out  OPND_WIDTH  operand size to mem32
mem_addr  out  ADDR_WIDTH  address to mem32
mem_wdata  out  DATA_WIDTH  write data to mem32 data_i
mem_rdata  in  DATA_WIDTH  load data from mem32 data_o

Behaviour:
- Reset values: all outputs 0; state IDLE; cnt 0; last-grant pointer = 1, so requester 0 wins the first tie.
- All outputs are registered.
- States: IDLE, BUSY.
- IDLE, on a rising edge with any reqN high:
  - Winner choice: only one requesting wins; if both request, CPU_PRIO=1 gives requester 0, CPU_PRIO=0 gives the requester not granted last.
  - Latch the winner's we/opnd/addr/wdata onto mem_* outputs; mem_ce <= winner's we.
  - gntN <= 1 for that cycle only; owner <= N; last <= N; cnt <= MEM_LAT-1; state <= BUSY.
- IDLE with no req: mem_ce <= 0; mem_addr, mem_opnd and mem_wdata hold their last values.
- BUSY:
  - mem_* outputs are held constant and all req inputs are ignored.
  - At each edge where cnt != 0: cnt <= cnt-1.
  - At the edge where cnt == 0: rdata_owner <= mem_rdata; rvalid_owner <= 1 for one cycle; mem_ce <= 0; state <= IDLE.
- rvalid pulses for writes too, as a completion strobe; rdata is then don't-care but still captured.
- Timing:
  - req high at edge k (IDLE) gives gnt high in cycle k..k+1.
  - rvalid high MEM_LAT cycles after gnt.
  - Next grant no earlier than the edge after rvalid rises; minimum issue interval is MEM_LAT+1 cycles.
- Requester protocol:
  - Hold reqN and its payload stable until gntN is seen high.
  - Deassert reqN, or present the next request, in the gnt cycle.
  - A request still high after gnt is treated as a new request once the arbiter is back in IDLE.
- Round-robin fairness: under continuous contention, grants alternate 0,1,0,1; a waiting requester is delayed by at most one transaction.
- CPU_PRIO=1: requester 1 may starve while req0 stays high; this is intended.
- gnt0 and gnt1 are never both high; rvalid0 and rvalid1 are never both high; gnt and rvalid of the same transaction never coincide.
- Async rst mid-BUSY: the transaction is aborted, no rvalid is issued, mem_ce drops immediately, all state returns to reset values.
- cnt is 4 bits wide.

Test Plan:
- MEM_LAT=1, req0 read addr 0x10, mem_rdata=0xDEADBEEF -> gnt0 one cycle after req sampled; rvalid0 next cycle with rdata0=0xDEADBEEF; mem_ce stays 0.
- MEM_LAT=3, req1 write addr 0x20 data 0x12345678 -> mem_ce=1, mem_addr=0x20, mem_wdata=0x12345678 held 3 cycles; then rvalid1 pulse and mem_ce=0.
- CPU_PRIO=0, req0 and req1 held high for 6 transactions -> grant order 0,1,0,1,0,1; never both gnt high.
- CPU_PRIO=1, both held high for 4 transactions -> gnt0 every time, gnt1 never; drop req0 -> gnt1 at the next IDLE.
- MEM_LAT=4, assert rst two cycles into BUSY -> all outputs 0 immediately, no rvalid; after release, requester 0 wins the first tie.
- Back-to-back: req0 re-asserted with a new address in the gnt cycle -> second gnt0 exactly MEM_LAT+1 cycles after the first.

Source files
------------

// File: rtl/chinx_memarb.sv
// chinx_memarb: two-requester arbiter/sequencer in front of the mem32 data port.
// Ports: req/we/opnd/addr/wdata in and gnt/rvalid/rdata out for each of requesters
//        0 (CPU) and 1 (DMA/debug); mem_ce/opnd/addr/wdata out and mem_rdata in.
//        All outputs are registered; clk is sysclk, rst is async active high.
module chinx_memarb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OPND_WIDTH = 2,
  parameter int MEM_LAT    = 1,
  parameter int CPU_PRIO   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [OPND_WIDTH-1:0] opnd0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [OPND_WIDTH-1:0] opnd1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_ce,
  output logic [OPND_WIDTH-1:0] mem_opnd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  owner, owner_n;
  logic                  last, last_n;
  logic                  win;
  logic                  ce_n;
  logic [OPND_WIDTH-1:0] opnd_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic                  gnt0_n, gnt1_n;
  logic                  rvalid0_n, rvalid1_n;
  logic [DATA_WIDTH-1:0] rdata0_n, rdata1_n;

  // On a tie, round-robin hands the port to whoever was not served last.
  always_comb begin
    if (req0 && req1)
      win = (CPU_PRIO != 0) ? 1'b0 : ~last;
    else
      win = ~req0;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    owner_n   = owner;
    last_n    = last;
    ce_n      = mem_ce;
    opnd_n    = mem_opnd;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    gnt0_n    = 1'b0;
    gnt1_n    = 1'b0;
    rvalid0_n = 1'b0;
    rvalid1_n = 1'b0;
    rdata0_n  = rdata0;
    rdata1_n  = rdata1;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_n = BUSY;
          cnt_n   = LAT_M1;
          owner_n = win;
          last_n  = win;
          if (win) begin
            ce_n    = we1;
            opnd_n  = opnd1;
            addr_n  = addr1;
            wdata_n = wdata1;
            gnt1_n  = 1'b1;
          end else begin
            ce_n    = we0;
            opnd_n  = opnd0;
            addr_n  = addr0;
            wdata_n = wdata0;
            gnt0_n  = 1'b1;
          end
        end else begin
          ce_n = 1'b0;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n = IDLE;
          ce_n    = 1'b0;
          // Captured for writes too; the strobe doubles as completion.
          if (owner) begin
            rdata1_n  = mem_rdata;
            rvalid1_n = 1'b1;
          end else begin
            rdata0_n  = mem_rdata;
            rvalid0_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner     <= 1'b0;
      last      <= 1'b1;
      mem_ce    <= 1'b0;
      mem_opnd  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      owner     <= owner_n;
      last      <= last_n;
      mem_ce    <= ce_n;
      mem_opnd  <= opnd_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      gnt0      <= gnt0_n;
      gnt1      <= gnt1_n;
      rvalid0   <= rvalid0_n;
      rvalid1   <= rvalid1_n;
      rdata0    <= rdata0_n;
      rdata1    <= rdata1_n;
    end
  end

endmodule

// File: tb/tb_chinx_memarb.sv
// tb_chinx_memarb: directed bench for chinx_memarb.
// Three instances share stimulus: [0] LAT=1 RR, [1] LAT=3 RR, [2] LAT=4 CPU priority.
module tb_chinx_memarb;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [1:0]  opnd0, opnd1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] mem_rdata;

  logic        gnt0_o[3], rvalid0_o[3], gnt1_o[3], rvalid1_o[3];
  logic [31:0] rdata0_o[3], rdata1_o[3];
  logic        ce_o[3];
  logic [1:0]  opnd_o[3];
  logic [31:0] addr_o[3], wdata_o[3];

  int nvec = 0;
  int nerr = 0;

  chinx_memarb #(.MEM_LAT(1), .CPU_PRIO(0)) u0 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .opnd0(opnd0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_o[0]), .rvalid0(rvalid0_o[0]), .rdata0(rdata0_o[0]),
    .req1(req1), .we1(we1), .opnd1(opnd1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_o[0]), .rvalid1(rvalid1_o[0]), .rdata1(rdata1_o[0]),
    .mem_ce(ce_o[0]), .mem_opnd(opnd_o[0]), .mem_addr(addr_o[0]),
    .mem_wdata(wdata_o[0]), .mem_rdata(mem_rdata)
  );

  chinx_memarb #(.MEM_LAT(3), .CPU_PRIO(0)) u1 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .opnd0(opnd0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_o[1]), .rvalid0(rvalid0_o[1]), .rdata0(rdata0_o[1]),
    .req1(req1), .we1(we1), .opnd1(opnd1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_o[1]), .rvalid1(rvalid1_o[1]), .rdata1(rdata1_o[1]),
    .mem_ce(ce_o[1]), .mem_opnd(opnd_o[1]), .mem_addr(addr_o[1]),
    .mem_wdata(wdata_o[1]), .mem_rdata(mem_rdata)
  );

  chinx_memarb #(.MEM_LAT(4), .CPU_PRIO(1)) u2 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .opnd0(opnd0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_o[2]), .rvalid0(rvalid0_o[2]), .rdata0(rdata0_o[2]),
    .req1(req1), .we1(we1), .opnd1(opnd1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_o[2]), .rvalid1(rvalid1_o[2]), .rdata1(rdata1_o[2]),
    .mem_ce(ce_o[2]), .mem_opnd(opnd_o[2]), .mem_addr(addr_o[2]),
    .mem_wdata(wdata_o[2]), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req0 = 0; we0 = 0; opnd0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; opnd1 = 0; addr1 = 0; wdata1 = 0;
    mem_rdata = 32'h0;
    #2;
    do_reset();

    // reset state
    for (int i = 0; i < 3; i++) begin
      chk("rst_gnt0", 32'(gnt0_o[i]), 0);
      chk("rst_rvalid1", 32'(rvalid1_o[i]), 0);
      chk("rst_ce", 32'(ce_o[i]), 0);
      chk("rst_addr", addr_o[i], 0);
      chk("rst_rdata0", rdata0_o[i], 0);
    end

    // LAT=1 read by requester 0
    mem_rdata = 32'hDEADBEEF;
    req0 = 1; we0 = 0; opnd0 = 2'd2; addr0 = 32'h10;
    tick();
    chk("rd_gnt0", 32'(gnt0_o[0]), 1);
    chk("rd_gnt1", 32'(gnt1_o[0]), 0);
    chk("rd_addr", addr_o[0], 32'h10);
    chk("rd_opnd", 32'(opnd_o[0]), 2);
    chk("rd_ce", 32'(ce_o[0]), 0);
    chk("rd_rv_early", 32'(rvalid0_o[0]), 0);
    req0 = 0;
    tick();
    chk("rd_rvalid0", 32'(rvalid0_o[0]), 1);
    chk("rd_rdata0", rdata0_o[0], 32'hDEADBEEF);
    chk("rd_gnt0_drop", 32'(gnt0_o[0]), 0);
    chk("rd_ce_after", 32'(ce_o[0]), 0);
    tick();
    chk("rd_rvalid0_pulse", 32'(rvalid0_o[0]), 0);

    // LAT=3 write by requester 1
    do_reset();
    mem_rdata = 32'hA5A5_0001;
    req1 = 1; we1 = 1; opnd1 = 2'd3; addr1 = 32'h20; wdata1 = 32'h12345678;
    tick();
    chk("wr_gnt1", 32'(gnt1_o[1]), 1);
    req1 = 0; addr1 = 32'hFFFF; wdata1 = 0; we1 = 0;
    for (int c = 0; c < 3; c++) begin
      chk("wr_ce_held", 32'(ce_o[1]), 1);
      chk("wr_addr_held", addr_o[1], 32'h20);
      chk("wr_wdata_held", wdata_o[1], 32'h12345678);
      chk("wr_no_rvalid", 32'(rvalid1_o[1]), 0);
      tick();
    end
    chk("wr_rvalid1", 32'(rvalid1_o[1]), 1);
    chk("wr_rvalid0", 32'(rvalid0_o[1]), 0);
    chk("wr_ce_drop", 32'(ce_o[1]), 0);
    chk("wr_addr_keep", addr_o[1], 32'h20);
    tick();
    chk("wr_rvalid1_pulse", 32'(rvalid1_o[1]), 0);

    // LAT=1 round robin under contention
    do_reset();
    req0 = 1; addr0 = 32'h100; we0 = 0;
    req1 = 1; addr1 = 32'h200; we1 = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("rr_gnt0", 32'(gnt0_o[0]), (t % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", 32'(gnt1_o[0]), (t % 2 == 1) ? 1 : 0);
      chk("rr_addr", addr_o[0], (t % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      chk("rr_idle_gnt", 32'({gnt0_o[0], gnt1_o[0]}), 0);
      chk("rr_rvalid0", 32'(rvalid0_o[0]), (t % 2 == 0) ? 1 : 0);
      chk("rr_rvalid1", 32'(rvalid1_o[0]), (t % 2 == 1) ? 1 : 0);
    end

    // LAT=4 CPU priority: requester 1 starves until req0 drops
    do_reset();
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("pr_gnt0", 32'(gnt0_o[2]), 1);
      chk("pr_gnt1", 32'(gnt1_o[2]), 0);
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("pr_busy_gnt1", 32'(gnt1_o[2]), 0);
      end
      chk("pr_rvalid0", 32'(rvalid0_o[2]), 1);
    end
    req0 = 0;
    tick();
    chk("pr_gnt1_late", 32'(gnt1_o[2]), 1);
    chk("pr_addr1", addr_o[2], 32'h200);
    req1 = 0;

    // LAT=4 async reset two cycles into BUSY
    do_reset();
    req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'hCAFE0040;
    tick();
    chk("ar_gnt0", 32'(gnt0_o[2]), 1);
    chk("ar_ce", 32'(ce_o[2]), 1);
    req0 = 0; we0 = 0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("ar_ce_now", 32'(ce_o[2]), 0);
    chk("ar_addr_now", addr_o[2], 0);
    chk("ar_wdata_now", wdata_o[2], 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ar_no_rvalid", 32'(rvalid0_o[2]), 0);
    end
    req0 = 1; req1 = 1; addr0 = 32'h44; addr1 = 32'h88;
    tick();
    chk("ar_tie_gnt0", 32'(gnt0_o[1]), 1);
    chk("ar_tie_gnt1", 32'(gnt1_o[1]), 0);
    chk("ar_tie_addr", addr_o[1], 32'h44);
    req0 = 0; req1 = 0;

    // LAT=3 back-to-back requests from requester 0
    do_reset();
    mem_rdata = 32'h0BADF00D;
    req0 = 1; we0 = 0; addr0 = 32'h300;
    tick();
    chk("bb_gnt0_a", 32'(gnt0_o[1]), 1);
    addr0 = 32'h304;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bb_gap", 32'(gnt0_o[1]), 0);
      chk("bb_addr_held", addr_o[1], 32'h300);
    end
    chk("bb_rvalid0", 32'(rvalid0_o[1]), 1);
    chk("bb_rdata0", rdata0_o[1], 32'h0BADF00D);
    tick();
    chk("bb_gnt0_b", 32'(gnt0_o[1]), 1);
    chk("bb_addr_b", addr_o[1], 32'h304);
    req0 = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
